multicycle_controller: RTL and testbench

//  Multi-cycle RV32 control FSM. Sequences one instruction through FETCH/DECODE/EXEC/MEM/WB,

---
 rtl/multicycle_controller.sv | 178 +++++++++++++++++
 tb/tb_multicycle_controller.sv | 184 ++++++++++++++++++
 2 files changed

// File: rtl/multicycle_controller.sv
// Multi-cycle RV32 control FSM: sequences FETCH/DECODE/EXEC/MEM/WB, stalls on mem_ready,
// traps on illegal opcodes or memory timeouts, and counts retired instructions.
module multicycle_controller #(
  parameter int unsigned TIMEOUT = 16,
  parameter int unsigned CNT_W   = 32,
  parameter bit          EN_JAL  = 1'b1,
  parameter bit          EN_LUI  = 1'b1
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic [31:0]      inst,
  input  logic             alu_zero,
  input  logic             mem_ready,
  output logic             mem_req,
  output logic             IorD,
  output logic             MemRead,
  output logic             MemWrite,
  output logic             IRWrite,
  output logic             PCWrite,
  output logic [1:0]       PCSrc,
  output logic             ALUSrcA,
  output logic [1:0]       ALUSrcB,
  output logic [1:0]       ALUOp,
  output logic             RegWrite,
  output logic [1:0]       WBSel,
  output logic             trap,
  output logic [CNT_W-1:0] retired
);

  typedef enum logic [2:0] {
    StIdle, StFetch, StDecode, StExec, StMem, StWb, StTrap
  } state_e;

  localparam logic [6:0] OpLoad   = 7'b0000011;
  localparam logic [6:0] OpStore  = 7'b0100011;
  localparam logic [6:0] OpR      = 7'b0110011;
  localparam logic [6:0] OpI      = 7'b0010011;
  localparam logic [6:0] OpBranch = 7'b1100011;
  localparam logic [6:0] OpJal    = 7'b1101111;
  localparam logic [6:0] OpLui    = 7'b0110111;

  localparam int unsigned TW = (TIMEOUT > 1) ? $clog2(TIMEOUT + 1) : 1;
  localparam logic [TW-1:0] TLast = TW'((TIMEOUT == 0) ? 0 : TIMEOUT - 1);

  state_e           state_q, state_d;
  logic [TW-1:0]    tcnt_q, tcnt_d;
  logic [CNT_W-1:0] retired_q, retired_d;

  logic [6:0] opcode;
  logic       is_ld, is_st, is_r, is_i, is_br, is_jal, is_lui, legal;
  logic       expire, retire;
  logic       unused_inst;

  assign unused_inst = ^inst[31:7];
  assign opcode = inst[6:0];
  assign is_ld  = (opcode == OpLoad);
  assign is_st  = (opcode == OpStore);
  assign is_r   = (opcode == OpR);
  assign is_i   = (opcode == OpI);
  assign is_br  = (opcode == OpBranch);
  assign is_jal = EN_JAL && (opcode == OpJal);
  assign is_lui = EN_LUI && (opcode == OpLui);
  assign legal  = is_ld | is_st | is_r | is_i | is_br | is_jal | is_lui;

  // Expiry is judged on the last waiting cycle; a simultaneous mem_ready still wins.
  assign expire = (TIMEOUT != 0) && (tcnt_q == TLast);

  always_comb begin
    state_d   = state_q;
    tcnt_d    = '0;
    retire    = 1'b0;
    mem_req   = 1'b0;
    IorD      = 1'b0;
    MemRead   = 1'b0;
    MemWrite  = 1'b0;
    IRWrite   = 1'b0;
    PCWrite   = 1'b0;
    PCSrc     = 2'b00;
    ALUSrcA   = 1'b0;
    ALUSrcB   = 2'b00;
    ALUOp     = 2'b00;
    RegWrite  = 1'b0;
    WBSel     = 2'b00;
    trap      = 1'b0;
    unique case (state_q)
      StIdle: state_d = StFetch;
      StFetch: begin
        mem_req = 1'b1;
        MemRead = 1'b1;
        ALUSrcB = 2'b01;
        if (mem_ready) begin
          IRWrite = 1'b1;
          PCWrite = 1'b1;
          state_d = StDecode;
        end else if (expire) begin
          state_d = StTrap;
        end else if (TIMEOUT != 0) begin
          tcnt_d = tcnt_q + TW'(1);
        end
      end
      StDecode: begin
        ALUSrcB = 2'b10;
        state_d = legal ? StExec : StTrap;
      end
      StExec: begin
        if (is_ld || is_st) begin
          ALUSrcA = 1'b1;
          ALUSrcB = 2'b10;
          state_d = StMem;
        end else if (is_r) begin
          ALUSrcA = 1'b1;
          ALUOp   = 2'b10;
          state_d = StWb;
        end else if (is_i) begin
          ALUSrcA = 1'b1;
          ALUSrcB = 2'b10;
          ALUOp   = 2'b10;
          state_d = StWb;
        end else if (is_lui) begin
          ALUSrcB = 2'b10;
          ALUOp   = 2'b11;
          state_d = StWb;
        end else if (is_br) begin
          ALUSrcA = 1'b1;
          ALUOp   = 2'b01;
          PCWrite = alu_zero;
          PCSrc   = 2'b01;
          retire  = 1'b1;
          state_d = StFetch;
        end else if (is_jal) begin
          PCWrite = 1'b1;
          PCSrc   = 2'b01;
          state_d = StWb;
        end else begin
          state_d = StTrap;
        end
      end
      StMem: begin
        mem_req  = 1'b1;
        IorD     = 1'b1;
        MemRead  = is_ld;
        MemWrite = is_st;
        if (mem_ready) begin
          retire  = is_st;
          state_d = is_ld ? StWb : StFetch;
        end else if (expire) begin
          state_d = StTrap;
        end else if (TIMEOUT != 0) begin
          tcnt_d = tcnt_q + TW'(1);
        end
      end
      StWb: begin
        RegWrite = 1'b1;
        WBSel    = is_ld ? 2'b01 : (is_jal ? 2'b10 : 2'b00);
        retire   = 1'b1;
        state_d  = StFetch;
      end
      StTrap: trap = 1'b1;
      default: state_d = StIdle;
    endcase
    retired_d = retire ? retired_q + CNT_W'(1) : retired_q;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q   <= StIdle;
      tcnt_q    <= '0;
      retired_q <= '0;
    end else begin
      state_q   <= state_d;
      tcnt_q    <= tcnt_d;
      retired_q <= retired_d;
    end
  end

  assign retired = retired_q;

endmodule

// File: tb/tb_multicycle_controller.sv
// Directed bench for multicycle_controller (TIMEOUT=4, CNT_W=4): a per-cycle vector table
// plus hand sequences for FETCH timeout, counter wrap and async reset mid-MEM.
module tb_multicycle_controller;

  logic        clk = 1'b0;
  logic        rst_n;
  logic [31:0] inst;
  logic        alu_zero, mem_ready;
  logic        mem_req, IorD, MemRead, MemWrite, IRWrite, PCWrite, ALUSrcA, RegWrite, trap;
  logic [1:0]  PCSrc, ALUSrcB, ALUOp, WBSel;
  logic [3:0]  retired;
  logic [16:0] ov;

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  multicycle_controller #(
    .TIMEOUT(4), .CNT_W(4), .EN_JAL(1'b1), .EN_LUI(1'b1)
  ) dut (
    .clk(clk), .rst_n(rst_n), .inst(inst), .alu_zero(alu_zero), .mem_ready(mem_ready),
    .mem_req(mem_req), .IorD(IorD), .MemRead(MemRead), .MemWrite(MemWrite),
    .IRWrite(IRWrite), .PCWrite(PCWrite), .PCSrc(PCSrc), .ALUSrcA(ALUSrcA),
    .ALUSrcB(ALUSrcB), .ALUOp(ALUOp), .RegWrite(RegWrite), .WBSel(WBSel),
    .trap(trap), .retired(retired)
  );

  // Order: req iord rd wr irw pcw pcsrc srca srcb aluop regw wbsel trap
  assign ov = {mem_req, IorD, MemRead, MemWrite, IRWrite, PCWrite, PCSrc, ALUSrcA,
               ALUSrcB, ALUOp, RegWrite, WBSel, trap};

  localparam logic [16:0] OIdle   = 17'b0_0_0_0_0_0_00_0_00_00_0_00_0;
  localparam logic [16:0] OFRdy   = 17'b1_0_1_0_1_1_00_0_01_00_0_00_0;
  localparam logic [16:0] OFWait  = 17'b1_0_1_0_0_0_00_0_01_00_0_00_0;
  localparam logic [16:0] ODec    = 17'b0_0_0_0_0_0_00_0_10_00_0_00_0;
  localparam logic [16:0] OExR    = 17'b0_0_0_0_0_0_00_1_00_10_0_00_0;
  localparam logic [16:0] OExI    = 17'b0_0_0_0_0_0_00_1_10_10_0_00_0;
  localparam logic [16:0] OExLs   = 17'b0_0_0_0_0_0_00_1_10_00_0_00_0;
  localparam logic [16:0] OExBrZ  = 17'b0_0_0_0_0_1_01_1_00_01_0_00_0;
  localparam logic [16:0] OExBrN  = 17'b0_0_0_0_0_0_01_1_00_01_0_00_0;
  localparam logic [16:0] OExLui  = 17'b0_0_0_0_0_0_00_0_10_11_0_00_0;
  localparam logic [16:0] OExJal  = 17'b0_0_0_0_0_1_01_0_00_00_0_00_0;
  localparam logic [16:0] OMemLw  = 17'b1_1_1_0_0_0_00_0_00_00_0_00_0;
  localparam logic [16:0] OMemSw  = 17'b1_1_0_1_0_0_00_0_00_00_0_00_0;
  localparam logic [16:0] OWbAlu  = 17'b0_0_0_0_0_0_00_0_00_00_1_00_0;
  localparam logic [16:0] OWbLw   = 17'b0_0_0_0_0_0_00_0_00_00_1_01_0;
  localparam logic [16:0] OWbJal  = 17'b0_0_0_0_0_0_00_0_00_00_1_10_0;
  localparam logic [16:0] OTrap   = 17'b0_0_0_0_0_0_00_0_00_00_0_00_1;

  localparam logic [6:0] OpLw = 7'b0000011, OpSw = 7'b0100011, OpR = 7'b0110011;
  localparam logic [6:0] OpI = 7'b0010011, OpBr = 7'b1100011, OpJal = 7'b1101111;
  localparam logic [6:0] OpLui = 7'b0110111, OpBad = 7'b0001111;

  typedef struct {
    logic [6:0]  op;
    logic        az;
    logic        rdy;
    logic [16:0] exp;
    logic [3:0]  ret;
  } vec_t;

  vec_t tbl[$];

  task automatic add(input logic [6:0] op, input logic az, input logic rdy,
                     input logic [16:0] exp, input logic [3:0] ret);
    tbl.push_back('{op: op, az: az, rdy: rdy, exp: exp, ret: ret});
  endtask

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  task automatic cyc();
    @(posedge clk);
    #1;
  endtask

  task automatic set_op(input logic [6:0] op);
    inst = {25'h1ABCDE5, op};
  endtask

  // Leaves the DUT in IDLE, 2 time units after a rising edge.
  task automatic do_reset();
    rst_n = 1'b0;
    alu_zero = 1'b0;
    mem_ready = 1'b0;
    set_op(OpR);
    repeat (2) @(posedge clk);
    #1;
    chk("reset_outputs", ov, OIdle);
    chk("reset_retired", retired, 0);
    rst_n = 1'b1;
    #1;
    chk("idle_after_reset", ov, OIdle);
  endtask

  initial begin
    // add
    add(OpR, 0, 1, OIdle, 0);   add(OpR, 0, 1, OFRdy, 0);  add(OpR, 0, 1, ODec, 0);
    add(OpR, 0, 1, OExR, 0);    add(OpR, 0, 1, OWbAlu, 0);
    // lw with 3 stall cycles in MEM (ready on the 4th, which is also the timeout boundary)
    add(OpLw, 0, 1, OFRdy, 1);  add(OpLw, 0, 1, ODec, 1);  add(OpLw, 0, 1, OExLs, 1);
    add(OpLw, 0, 0, OMemLw, 1); add(OpLw, 0, 0, OMemLw, 1); add(OpLw, 0, 0, OMemLw, 1);
    add(OpLw, 0, 1, OMemLw, 1); add(OpLw, 0, 1, OWbLw, 1);
    // beq taken / not taken
    add(OpBr, 1, 1, OFRdy, 2);  add(OpBr, 1, 1, ODec, 2);  add(OpBr, 1, 1, OExBrZ, 2);
    add(OpBr, 0, 1, OFRdy, 3);  add(OpBr, 0, 1, ODec, 3);  add(OpBr, 0, 1, OExBrN, 3);
    // addi, jal, lui
    add(OpI, 0, 1, OFRdy, 4);   add(OpI, 0, 1, ODec, 4);   add(OpI, 0, 1, OExI, 4);
    add(OpI, 0, 1, OWbAlu, 4);
    add(OpJal, 0, 1, OFRdy, 5); add(OpJal, 0, 1, ODec, 5); add(OpJal, 0, 1, OExJal, 5);
    add(OpJal, 0, 1, OWbJal, 5);
    add(OpLui, 0, 1, OFRdy, 6); add(OpLui, 0, 1, ODec, 6); add(OpLui, 0, 1, OExLui, 6);
    add(OpLui, 0, 1, OWbAlu, 6);
    // illegal opcode after a FETCH stall with ready on the 4th waiting cycle
    add(OpBad, 0, 0, OFWait, 7); add(OpBad, 0, 0, OFWait, 7); add(OpBad, 0, 0, OFWait, 7);
    add(OpBad, 0, 1, OFRdy, 7);  add(OpBad, 0, 1, ODec, 7);   add(OpBad, 0, 1, OTrap, 7);
    add(OpR, 1, 1, OTrap, 7);    add(OpSw, 0, 1, OTrap, 7);

    do_reset();
    for (int i = 0; i < tbl.size(); i++) begin
      set_op(tbl[i].op);
      alu_zero = tbl[i].az;
      mem_ready = tbl[i].rdy;
      #1;
      chk($sformatf("row%0d_outputs", i), ov, tbl[i].exp);
      chk($sformatf("row%0d_retired", i), retired, tbl[i].ret);
      @(posedge clk);
      #1;
    end

    // FETCH timeout: 4 waiting cycles with mem_ready low -> TRAP, mem_req dropped
    do_reset();
    cyc();
    for (int i = 0; i < 4; i++) begin
      chk($sformatf("fetch_wait%0d", i), ov, OFWait);
      cyc();
    end
    chk("fetch_timeout_trap", ov, OTrap);
    chk("fetch_timeout_retired", retired, 0);
    cyc();
    chk("trap_sticky", ov, OTrap);

    // 17 back-to-back sw: 4-bit counter wraps 15 -> 0 -> 1
    do_reset();
    set_op(OpSw);
    mem_ready = 1'b1;
    cyc();
    for (int i = 0; i < 17; i++) begin
      cyc();
      cyc();
      cyc();
      if (i == 0) chk("sw_mem_outputs", ov, OMemSw);
      cyc();
      if (i >= 14) chk($sformatf("sw_retired_%0d", i + 1), retired, (i + 1) % 16);
    end
    // Abort the 18th sw while stalled in MEM
    cyc();
    cyc();
    cyc();
    mem_ready = 1'b0;
    #1;
    chk("sw_mem_stall", ov, OMemSw);
    rst_n = 1'b0;
    #1;
    chk("abort_outputs", ov, OIdle);
    chk("abort_retired", retired, 0);
    cyc();
    rst_n = 1'b1;
    #1;
    chk("abort_idle", ov, OIdle);
    cyc();
    chk("abort_refetch", ov, OFWait);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
